// File: rtl/count_window_pkg.sv
// Shared types and constants for the count window sampler.
// Holds the FSM state encoding, the result record pushed into the result
// FIFO, and the counter's saturation value.
package count_window_pkg;

    localparam int CNT_W_DEF     = 32;
    localparam int WIN_W_DEF     = 24;
    localparam int RES_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // One measured window: saturation flag above the end-minus-base delta.
    typedef struct packed {
        logic                 sat;
        logic [CNT_W_DEF-1:0] delta;
    } res_t;

    // Value the counter sticks at once it saturates.
    localparam logic [CNT_W_DEF-1:0] SAT_VALUE = {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/count_window_sampler_win_res_fifo.sv
// Small synchronous result FIFO built as a shift register so that the head
// entry is always a flop (stable while it is not popped). A pop and a push in
// the same cycle on a full FIFO both succeed; a push into a full FIFO with no
// pop is dropped and latches the sticky overflow flag until reset.
module win_res_fifo #(
    parameter int DATA_W = 33,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_head,
    output logic              o_ovf
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] r_mem     [DEPTH];
    logic [DATA_W-1:0] w_mem_nxt [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_wr_idx;
    logic              r_valid;
    logic              r_ovf;
    logic              w_full;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_drop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop     = i_pop & r_valid;
    assign w_push_ok = i_push & (~w_full | w_pop);
    assign w_drop    = i_push & ~w_push_ok;

    // Next storage contents: shift down on pop, then write the new entry just past the survivors.
    always_comb begin
        w_count_nxt = r_count;
        w_wr_idx    = r_count;
        if (w_pop) begin
            w_wr_idx = r_count - CNT_W'(1'b1);
        end else begin
            w_wr_idx = r_count;
        end
        if (w_pop && !w_push_ok) begin
            w_count_nxt = r_count - CNT_W'(1'b1);
        end else if (!w_pop && w_push_ok) begin
            w_count_nxt = r_count + CNT_W'(1'b1);
        end else begin
            w_count_nxt = r_count;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push_ok && (CNT_W'(i) == w_wr_idx)) begin
                w_mem_nxt[i] = i_data;
            end else if (w_pop) begin
                w_mem_nxt[i] = r_mem[(i < DEPTH - 1) ? i + 1 : i];
            end else begin
                w_mem_nxt[i] = r_mem[i];
            end
        end
    end

    // Storage, occupancy and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {CNT_W{1'b0}};
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else begin
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != {CNT_W{1'b0}});
            r_ovf   <= r_ovf | w_drop;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_mem_nxt[i];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_head  = r_mem[0];
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/count_window_sampler.sv
// Control and readout stage for the event counter. Each accepted arm opens a
// window of win_len clk cycles (0 behaves as 1) during which start is held
// high; the counter value is snapshotted before and after, and the delta plus
// a saturation flag are queued in a small result FIFO.
// Optional build macro COUNT_WINDOW_CONT_MODE_EN adds the cont input: while
// cont is high at the end of a window the next window begins immediately with
// start held high, the capture cycle counting as the first cycle of the new
// window, so consecutive deltas partition the count exactly.
module count_window_sampler
    import count_window_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int WIN_W     = WIN_W_DEF,
    parameter int RES_DEPTH = RES_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] cnt,
    input  logic             cnt_full,
`ifdef COUNT_WINDOW_CONT_MODE_EN
    input  logic             cont,
`endif
    output logic             start,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_delta,
    output logic             res_sat,
    output logic             res_ovf
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_base;
    logic [CNT_W-1:0] w_base_nxt;
    logic [WIN_W-1:0] r_timer;
    logic [WIN_W-1:0] w_timer_nxt;
    logic [WIN_W-1:0] w_len_eff;
    logic             r_sat_seen;
    logic             w_sat_seen_nxt;
    logic             r_start;
    logic             w_start_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             w_cont;
    logic             w_push;
    logic             w_push_sat;
    logic [CNT_W-1:0] w_delta;
    logic [CNT_W:0]   w_head;

`ifdef COUNT_WINDOW_CONT_MODE_EN
    assign w_cont = cont;
`else
    assign w_cont = 1'b0;
`endif

    assign w_len_eff = (win_len == {WIN_W{1'b0}}) ? WIN_W'(1'b1) : win_len;

    // Next-state, snapshot and output decode for the window FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_base_nxt     = r_base;
        w_timer_nxt    = r_timer;
        w_sat_seen_nxt = r_sat_seen;
        w_start_nxt    = r_start;
        w_busy_nxt     = r_busy;
        w_push         = 1'b0;
        w_push_sat     = r_sat_seen | cnt_full | (&cnt);
        w_delta        = cnt - r_base;
        case (r_state)
            IDLE: begin
                w_start_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                if (arm) begin
                    w_state_nxt    = RUN;
                    w_base_nxt     = cnt;
                    w_timer_nxt    = w_len_eff;
                    w_sat_seen_nxt = cnt_full;
                    w_start_nxt    = 1'b1;
                    w_busy_nxt     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_start_nxt    = 1'b1;
                w_busy_nxt     = 1'b1;
                w_sat_seen_nxt = r_sat_seen | cnt_full;
                if (r_timer == WIN_W'(1'b1)) begin
                    w_state_nxt = CAPTURE;
                    // Continuing windows keep start high through the capture cycle.
                    w_start_nxt = w_cont;
                end else begin
                    w_timer_nxt = r_timer - WIN_W'(1'b1);
                end
            end
            CAPTURE: begin
                w_push = 1'b1;
                if (w_cont) begin
                    // Capture cycle already counts toward the next window.
                    w_base_nxt     = cnt;
                    w_sat_seen_nxt = cnt_full;
                    w_start_nxt    = 1'b1;
                    w_busy_nxt     = 1'b1;
                    if (w_len_eff == WIN_W'(1'b1)) begin
                        w_state_nxt = CAPTURE;
                        w_timer_nxt = w_len_eff;
                    end else begin
                        w_state_nxt = RUN;
                        w_timer_nxt = w_len_eff - WIN_W'(1'b1);
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_start_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_start_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state, window snapshot and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= {CNT_W{1'b0}};
            r_timer    <= {WIN_W{1'b0}};
            r_sat_seen <= 1'b0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_base     <= w_base_nxt;
            r_timer    <= w_timer_nxt;
            r_sat_seen <= w_sat_seen_nxt;
            r_start    <= w_start_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    win_res_fifo #(
        .DATA_W (CNT_W + 1),
        .DEPTH  (RES_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({w_push_sat, w_delta}),
        .i_pop   (res_ready),
        .o_valid (res_valid),
        .o_head  (w_head),
        .o_ovf   (res_ovf)
    );

    assign start     = r_start;
    assign busy      = r_busy;
    assign res_delta = w_head[CNT_W-1:0];
    assign res_sat   = w_head[CNT_W];

endmodule
